// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic            is_word_op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd_in;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (output start, funct3, is_word_op, a, b, rd_in, flush,
                  input  busy, done, result, rd_out);
  modport slave  (input  start, funct3, is_word_op, a, b, rd_in, flush,
                  output busy, done, result, rd_out);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: radix-2 shift-add multiply, restoring
// divide, sign correction in FIX, divide-by-zero/overflow resolved at accept.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [2:0]      op;
  logic            word, neg_p, neg_r;
  logic [6:0]      cnt;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] hi, lo, mb;

  function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // accept-time decode
  logic [2:0]      f3;
  logic            is_div, wmode, sgn_a, sgn_b, na, nb, div0, ovf;
  logic [XLEN-1:0] ea, eb, ma, mbv, byp_res, min_neg;

  always_comb begin
    f3      = bus.funct3;
    is_div  = f3[2];
    wmode   = (XLEN == 64) && bus.is_word_op && (f3 == 3'b000 || f3[2]);
    sgn_a   = !(f3 == 3'b011 || f3 == 3'b101 || f3 == 3'b111);
    sgn_b   = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b110);
    ea      = wmode ? (sgn_a ? sx32(bus.a[31:0]) : XLEN'(bus.a[31:0])) : bus.a;
    eb      = wmode ? (sgn_b ? sx32(bus.b[31:0]) : XLEN'(bus.b[31:0])) : bus.b;
    na      = sgn_a & ea[XLEN-1];
    nb      = sgn_b & eb[XLEN-1];
    ma      = na ? -ea : ea;
    mbv     = nb ? -eb : eb;
    min_neg = XLEN'(1) << (XLEN - 1);
    div0    = is_div && (eb == '0);
    ovf     = is_div && !f3[0] && (eb == '1) &&
              (wmode ? (ea[31:0] == 32'h8000_0000) : (ea == min_neg));
    byp_res = '0;
    if (div0)     byp_res = f3[1] ? (wmode ? sx32(bus.a[31:0]) : bus.a) : '1;
    else if (ovf) byp_res = f3[1] ? '0 : ea;
  end

  // datapath steps and output selection
  logic [XLEN:0]   msum, dt;
  logic            dge;
  logic [XLEN-1:0] ddiff, phi, mlo, mlo_n, q, r, raw, fix_res;
  logic [6:0]      last;

  always_comb begin
    msum    = {1'b0, hi} + {1'b0, (lo[0] ? mb : '0)};
    dt      = {hi, lo[XLEN-1]};
    dge     = dt >= {1'b0, mb};
    ddiff   = dt[XLEN-1:0] - mb;
    // high half of the negated product: carry reaches it only when lo is zero
    phi     = neg_p ? (~hi + XLEN'(lo == '0)) : hi;
    // a 32-step multiply leaves the word product low half in lo[XLEN-1 -: 32]
    mlo     = word ? (lo >> (XLEN - 32)) : lo;
    mlo_n   = neg_p ? -mlo : mlo;
    q       = neg_p ? -lo : lo;
    r       = neg_r ? -hi : hi;
    case (op)
      3'b000:                 raw = mlo_n;
      3'b001, 3'b010, 3'b011: raw = phi;
      3'b100, 3'b101:         raw = q;
      default:                raw = r;
    endcase
    fix_res = word ? sx32(raw[31:0]) : raw;
    last    = word ? 7'd31 : 7'(XLEN - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.rd_out <= '0;
      cnt        <= '0;
      op         <= '0;
      word       <= 1'b0;
      neg_p      <= 1'b0;
      neg_r      <= 1'b0;
      rd_q       <= '0;
      hi         <= '0;
      lo         <= '0;
      mb         <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start && !bus.flush) begin
          op       <= f3;
          word     <= wmode;
          rd_q     <= bus.rd_in;
          cnt      <= '0;
          neg_p    <= na ^ nb;
          neg_r    <= na;
          bus.busy <= 1'b1;
          if (div0 || ovf) begin
            bus.result <= byp_res;
            bus.rd_out <= bus.rd_in;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else begin
            hi    <= '0;
            mb    <= mbv;
            // word divides walk the 32-bit dividend from the top of lo
            lo    <= (is_div && wmode) ? (ma << (XLEN - 32)) : ma;
            state <= CALC;
          end
        end
        CALC: if (bus.flush) begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end else begin
          if (op[2]) begin
            hi <= dge ? ddiff : dt[XLEN-1:0];
            lo <= {lo[XLEN-2:0], dge};
          end else begin
            hi <= msum[XLEN:1];
            lo <= {msum[0], lo[XLEN-1:1]};
          end
          cnt <= cnt + 7'd1;
          if (cnt == last) state <= FIX;
        end
        FIX: if (bus.flush) begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end else begin
          bus.result <= fix_res;
          bus.rd_out <= rd_q;
          bus.done   <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: one XLEN=32 and one XLEN=64 instance.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) m32();
  muldiv_unit_if #(.XLEN(64)) m64();
  muldiv_unit #(.XLEN(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(m32));
  muldiv_unit #(.XLEN(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(m64));

  typedef struct {bit sel; logic [63:0] res; logic [4:0] rd;} exp_t;
  exp_t sbq[$];
  int nvec = 0, nerr = 0;
  logic [63:0] last_exp32 = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    logic signed [31:0] t;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'({32'b0, x}); uy = longint'({32'b0, y});
    case (f)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        t = $signed(x) / $signed(y); return t;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        t = $signed(x) % $signed(y); return t;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  function automatic logic [63:0] sx64(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // completion monitors: every done must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m32.done) begin
      if (sbq.size() == 0 || sbq[0].sel) chk("done32_unexpected", {63'b0, m32.done}, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("res32", {32'b0, m32.result}, e.res);
        chk("rd32", {59'b0, m32.rd_out}, {59'b0, e.rd});
      end
    end
    if (rst_n && m64.done) begin
      if (sbq.size() == 0 || !sbq[0].sel) chk("done64_unexpected", {63'b0, m64.done}, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("res64", m64.result, e.res);
        chk("rd64", {59'b0, m64.rd_out}, {59'b0, e.rd});
      end
    end
  end

  task automatic set_req(input bit sel, input bit st, input logic [2:0] f, input bit w,
                         input logic [63:0] x, input logic [63:0] y, input logic [4:0] rd);
    if (sel) begin
      m64.start = st; m64.funct3 = f; m64.is_word_op = w; m64.a = x; m64.b = y; m64.rd_in = rd;
    end else begin
      m32.start = st; m32.funct3 = f; m32.is_word_op = w; m32.a = x[31:0]; m32.b = y[31:0]; m32.rd_in = rd;
    end
  endtask

  // poke: extra starts while busy and during the DONE cycle, both must be ignored
  task automatic issue(input bit sel, input logic [2:0] f, input bit w, input logic [63:0] x,
                       input logic [63:0] y, input logic [4:0] rd, input logic [63:0] exp,
                       input int lat, input bit poke);
    int cyc, nb;
    bit dn, bz;
    @(negedge clk);
    set_req(sel, 1'b1, f, w, x, y, rd);
    sbq.push_back('{sel, exp, rd});
    @(negedge clk);
    set_req(sel, 1'b0, f, w, x, y, rd);
    cyc = 1; nb = 0;
    forever begin
      dn = sel ? m64.done : m32.done;
      bz = sel ? m64.busy : m32.busy;
      if (!bz) nb++;
      if (dn || cyc >= 100) break;
      if (poke && cyc == 5) set_req(sel, 1'b1, ~f, w, ~x, y + 64'd1, ~rd);
      if (poke && cyc == 6) set_req(sel, 1'b0, f, w, x, y, rd);
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(lat));
    chk("busy_during_op", 64'(nb), 64'd0);
    if (!dn) void'(sbq.pop_back());
    if (!sel) last_exp32 = exp;
    if (poke) begin
      set_req(sel, 1'b1, ~f, w, ~x, y, ~rd);
      @(negedge clk);
      set_req(sel, 1'b0, f, w, x, y, rd);
      repeat (40) @(negedge clk);
    end
  endtask

  typedef struct {logic [2:0] f; logic [31:0] x, y, e; int lat;} v32_t;
  v32_t tv[$];

  initial begin
    logic [31:0] rx, ry;
    logic [2:0]  rf;
    logic [63:0] wx, wy;
    set_req(1'b0, 1'b0, 3'd0, 1'b0, 64'd0, 64'd0, 5'd0);
    set_req(1'b1, 1'b0, 3'd0, 1'b0, 64'd0, 64'd0, 5'd0);
    m32.flush = 1'b0; m64.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {62'b0, m32.busy, m64.busy}, 64'd0);
    chk("rst_done", {62'b0, m32.done, m64.done}, 64'd0);
    chk("rst_res32", {32'b0, m32.result}, 64'd0);
    chk("rst_res64", m64.result, 64'd0);
    chk("rst_rd", {54'b0, m32.rd_out, m64.rd_out}, 64'd0);
    rst_n = 1'b1;

    tv = '{'{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
           '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
           '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 34},
           '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34},
           '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34},
           '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34},
           '{3'd5, 32'd7, 32'd2, 32'd3, 34},
           '{3'd7, 32'd7, 32'd2, 32'd1, 34},
           '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1},
           '{3'd6, 32'd5, 32'd0, 32'd5, 1},
           '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
           '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1},
           '{3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1},
           '{3'd7, 32'h1234_5678, 32'd0, 32'h1234_5678, 1}};
    foreach (tv[i])
      issue(1'b0, tv[i].f, 1'b0, {32'b0, tv[i].x}, {32'b0, tv[i].y}, 5'(i + 1),
            {32'b0, tv[i].e}, tv[i].lat, 1'b0);

    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = (i % 4 == 3) ? 32'($urandom_range(0, 9)) : $urandom;
      issue(1'b0, rf, 1'b0, {32'b0, rx}, {32'b0, ry}, 5'($urandom),
            {32'b0, ref32(rf, rx, ry)}, lat32(rf, rx, ry), 1'b0);
    end

    // flush mid-CALC: no done, busy drops, result holds
    @(negedge clk);
    set_req(1'b0, 1'b1, 3'd0, 1'b0, 64'd9, 64'd9, 5'd3);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'd0, 1'b0, 64'd9, 64'd9, 5'd3);
    repeat (9) @(negedge clk);
    m32.flush = 1'b1;
    @(negedge clk);
    m32.flush = 1'b0;
    chk("flush_busy", {63'b0, m32.busy}, 64'd0);
    chk("flush_done", {63'b0, m32.done}, 64'd0);
    chk("flush_hold", {32'b0, m32.result}, last_exp32);
    repeat (2) @(negedge clk);
    issue(1'b0, 3'd0, 1'b0, 64'd6, 64'd7, 5'd5, 64'd42, 34, 1'b0);

    // flush and start together while idle: request dropped
    @(negedge clk);
    set_req(1'b0, 1'b1, 3'd5, 1'b0, 64'd8, 64'd2, 5'd9);
    m32.flush = 1'b1;
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'd5, 1'b0, 64'd8, 64'd2, 5'd9);
    m32.flush = 1'b0;
    chk("flush_start_busy", {63'b0, m32.busy}, 64'd0);
    repeat (40) @(negedge clk);

    // extra starts while busy and during DONE are ignored
    issue(1'b0, 3'd5, 1'b0, 64'd100, 64'd7, 5'd11, 64'd14, 34, 1'b1);

    // asynchronous reset mid-CALC
    @(negedge clk);
    set_req(1'b0, 1'b1, 3'd0, 1'b0, 64'd3, 64'd3, 5'd4);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'd0, 1'b0, 64'd3, 64'd3, 5'd4);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'b0, m32.busy}, 64'd0);
    chk("arst_done", {63'b0, m32.done}, 64'd0);
    chk("arst_res", {32'b0, m32.result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // XLEN=64: word ops and full-width ops
    issue(1'b1, 3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1,
          64'hFFFF_FFFF_8000_0000, 1, 1'b0);
    issue(1'b1, 3'd0, 1'b1, 64'h10000, 64'h10000, 5'd2, 64'd0, 34, 1'b0);
    issue(1'b1, 3'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd3, 64'hF, 34, 1'b0);
    issue(1'b1, 3'd0, 1'b0, 64'h1_0000_0000, 64'd3, 5'd4, 64'h3_0000_0000, 66, 1'b0);
    issue(1'b1, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'd1, 66, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rf = (i % 5 == 0) ? 3'd0 : 3'($urandom_range(4, 7));
      wx = {$urandom, $urandom};
      wy = {$urandom, (i == 3) ? 32'd0 : $urandom};
      issue(1'b1, rf, 1'b1, wx, wy, 5'($urandom), sx64(ref32(rf, wx[31:0], wy[31:0])),
            lat32(rf, wx[31:0], wy[31:0]), 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide unit, parametrised in XLEN, sitting beside the single-cycle ALU in EX.
- Adds multi-cycle operation and word-op (W-suffix) handling, which the single-cycle ALU does not provide.
- The hazard unit holds the pipeline while busy is high and writes the result back on done, tagged with rd.

Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when busy=0 and flush=0.
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- is_word_op  in  1  W-variant select; honoured only when XLEN=64 and funct3 is not 001..011; otherwise ignored.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- rd_in  in  5  destination register tag.
- flush  in  1  synchronous abort of any operation in progress.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  single-cycle result-valid pulse.
- result  out  XLEN  result, valid while done=1.
- rd_out  out  5  tag captured at accept.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0. Takes effect immediately, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on the edge where start=1 and flush=0.
  - At accept, latch |a|, |b|, the result-sign flags, funct3, word mode and rd_in; clear the counter.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU/DIVU/REMU treat both as unsigned.
- Word mode: operands are taken from bits [31:0] (sign- or zero-extended per op); N=32 iterations; the final result is bits [31:0] sign-extended to 64.
- Otherwise N=XLEN iterations.
- CALC, one step per edge:
  - Multiply: radix-2 shift-add into a 2*XLEN product.
  - Divide: restoring, one quotient bit per step.
  - After step N, go to FIX.
- FIX (one edge): apply sign correction (two's-complement negate where needed), then select the output:
  - MUL: low half of the product.
  - MULH*: high half of the product.
  - DIV*: quotient.
  - REM*: remainder; the remainder takes the sign of the dividend.
  - Register the selected value into result, then go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. A start during DONE is ignored.
- Latency: done is high in cycle N+2 after the accept edge (34 for XLEN=32 or word ops; 66 for XLEN=64).
- Special cases bypass CALC and go IDLE -> DONE directly, so done is high in the cycle right after the accept edge:
  - Divide by zero: DIV/DIVU give all-ones (in word mode, 32 ones sign-extended); REM/REMU give the dividend (in word mode, sign-extended low 32 bits).
  - Signed overflow (most-negative / -1, using 32-bit values in word mode): DIV gives the dividend; REM gives 0.
- start while busy=1: ignored. No queueing; the latched operands are unaffected.
- flush=1 in any non-IDLE state: IDLE on the next edge, done suppressed, result keeps its prior value.
- flush=1 and start=1 in the same cycle while IDLE: flush wins and the request is dropped.
- result and rd_out hold their values after done falls until the next completion.

Test Plan:
- XLEN=32, MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 34 cycles after accept, busy high throughout.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 7/2 -> 3; REMU 7/2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0. Each completes with done one cycle after accept.
- Control sequence:
  - Flush at CALC step 10: no done pulse, busy=0 next cycle.
  - A start 3 cycles later, with rd_in=5, is accepted and completes with rd_out=5.
  - A start issued while busy produces no second done.
  - rst_n low mid-CALC clears busy/done/result immediately.
- XLEN=64 word mode:
  - DIVW a=0x00000001_80000000, b=-1 -> 0xFFFFFFFF_80000000 (overflow path).
  - MULW 0x10000 x 0x10000 -> 0.
  - REMUW 0xFFFFFFFF_FFFFFFFF % 0x10 -> 0x00000000_0000000F.
  - Non-bypass word ops complete in 34 cycles.
